csi_rx_cfg_sequencer: RTL

CSI_RX_CFG_SEQUENCER -- requirements
Module: csi_rx_cfg_sequencer

---
 rtl/csi_rx_cfg_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/csi_rx_cfg_sequencer.sv
// Writes a table of CSI RX register values over AXI4-Lite, then services status interrupts.
// Build option CSI_CFG_READBACK_EN adds a read-back compare after every table write.
module csi_rx_cfg_sequencer #(
  parameter int unsigned NUM_CFG        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [5:0]  STATUS_ADDR    = 6'h04
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [NUM_CFG*6-1:0]  cfg_addr,
  input  logic [NUM_CFG*32-1:0] cfg_data,
  input  logic                  irq,
  output logic [5:0]            axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [31:0]           axi_wdata,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [5:0]            axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [31:0]           axi_rdata,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [15:0]           irq_count,
  output logic [31:0]           last_status
);

  localparam int unsigned IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CFG - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, WR, WR_RESP,
`ifdef CSI_CFG_READBACK_EN
    RB_AR, RB_R,
`endif
    MONITOR, IRQ_AR, IRQ_R, CLR_WR, CLR_RESP, ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             done_q, done_d, err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      status_q, status_d;

  logic             enter, entry_done, restart, aw_ok, w_ok;
  logic [5:0]       cur_addr;
  logic [31:0]      cur_data;

  assign cur_addr = cfg_addr[6*int'(idx_q) +: 6];
  assign cur_data = cfg_data[32*int'(idx_q) +: 32];

  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign irq_count   = cnt_q;
  assign last_status = status_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    done_d      = done_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    status_d    = status_q;
    enter       = 1'b0;
    entry_done  = 1'b0;
    restart     = 1'b0;
    aw_ok       = 1'b0;
    w_ok        = 1'b0;
    axi_awaddr  = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_araddr  = '0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    cfg_busy    = 1'b1;

    case (state_q)
      IDLE: begin
        cfg_busy = 1'b0;
        restart  = 1'b1;
      end
      // AW and W complete independently; each valid drops once its own handshake is seen.
      WR, CLR_WR: begin
        axi_awvalid = !aw_done_q;
        axi_wvalid  = !w_done_q;
        if (axi_awvalid) axi_awaddr = (state_q == WR) ? cur_addr : STATUS_ADDR;
        if (axi_wvalid)  axi_wdata  = (state_q == WR) ? cur_data : status_q;
        aw_ok     = aw_done_q | axi_awready;
        w_ok      = w_done_q | axi_wready;
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) begin
          state_d = (state_q == WR) ? WR_RESP : CLR_RESP;
          enter   = 1'b1;
        end
      end
      WR_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
`ifdef CSI_CFG_READBACK_EN
          state_d = RB_AR;
          enter   = 1'b1;
`else
          entry_done = 1'b1;
`endif
        end
      end
`ifdef CSI_CFG_READBACK_EN
      RB_AR: begin
        axi_arvalid = 1'b1;
        axi_araddr  = cur_addr;
        if (axi_arready) begin
          state_d = RB_R;
          enter   = 1'b1;
        end
      end
      RB_R: begin
        axi_rready = 1'b1;
        if (axi_rvalid) begin
          if (axi_rdata != cur_data) err_d = 1'b1;
          entry_done = 1'b1;
        end
      end
`endif
      MONITOR: begin
        cfg_busy = 1'b0;
        if (start) begin
          restart = 1'b1;
        end else if (irq) begin
          state_d = IRQ_AR;
          enter   = 1'b1;
        end
      end
      IRQ_AR: begin
        axi_arvalid = 1'b1;
        axi_araddr  = STATUS_ADDR;
        if (axi_arready) begin
          state_d = IRQ_R;
          enter   = 1'b1;
        end
      end
      IRQ_R: begin
        axi_rready = 1'b1;
        if (axi_rvalid) begin
          status_d = axi_rdata;
          state_d  = CLR_WR;
          enter    = 1'b1;
        end
      end
      CLR_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          state_d = MONITOR;
          enter   = 1'b1;
        end
      end
      ERROR: begin
        cfg_busy = 1'b0;
        if (start) restart = 1'b1;
      end
      default: begin
        state_d = IDLE;
        enter   = 1'b1;
      end
    endcase

    if (entry_done) begin
      enter = 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = MONITOR;
        done_d  = 1'b1;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = WR;
      end
    end

    if (restart) begin
      enter   = 1'b1;
      idx_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      state_d = WR;
    end

    // Any state entry (including WR->WR for the next entry) reloads the handshake timer.
    if (enter) begin
      tmr_d     = '0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else if (cfg_busy) begin
      if (tmr_q == TMR_LAST) begin
        state_d = ERROR;
        err_d   = 1'b1;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end
  end

endmodule
